// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control unit: opcode values,
// ALUOp codes, FSM state encodings, datapath mux select codes, the packed
// control word handed from the decode table to the top, and two helper
// functions that classify opcodes.
//
// Configuration macro: MULTICYCLE_CTRL_JAL_EN
//   defined   -> opcode 03 (JAL) is a legal instruction with its own state
//   undefined -> opcode 03 is treated as illegal
package mips_ctrl_pkg;

   // Opcode field values (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // ALUOp codes as understood by the ALU control
   localparam logic [2:0] ALU_LUI = 3'b001;
   localparam logic [2:0] ALU_BEQ = 3'b010;
   localparam logic [2:0] ALU_BNE = 3'b011;
   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_AND = 3'b110;
   localparam logic [2:0] ALU_R   = 3'b111;

   // Register-file destination select
   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;

   // Register-file write-data select
   localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
   localparam logic [1:0] MEMTOREG_MDR    = 2'b01;

`ifdef MULTICYCLE_CTRL_JAL_EN
   // Link register ($31) and return-address write data, only reachable with JAL
   localparam logic [1:0] REGDST_RA   = 2'b10;
   localparam logic [1:0] MEMTOREG_PC = 2'b10;
`endif

   // ALU B-operand select
   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BRANCH = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // FSM states; encodings 14 and 15 are unused and recover to FETCH.
   // S_JAL keeps its encoding even when JAL is disabled, it is simply unreachable.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_RTEXE  = 4'd3,
      S_RTWB   = 4'd4,
      S_ITEXE  = 4'd5,
      S_ITWB   = 4'd6,
      S_MEMADR = 4'd7,
      S_MEMRD  = 4'd8,
      S_MEMWB  = 4'd9,
      S_MEMWR  = 4'd10,
      S_BRANCH = 4'd11,
      S_JUMP   = 4'd12,
      S_JAL    = 4'd13
   } state_e;

   // Every datapath control produced in one cycle
   typedef struct packed {
      logic       pcWrite;
      logic       branchEq;
      logic       branchNe;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic [1:0] regDst;
      logic [1:0] memtoReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] pcSource;
      logic [2:0] aluOp;
      logic       illegalOp;
   } ctrlWord_t;

   // Maps an opcode to the state that follows DECODE.
   // S_FETCH doubles as the "illegal opcode" answer, since that is where an
   // unknown instruction goes anyway.
   function automatic state_e opTarget(input logic [5:0] op);
      state_e target;
      case (op)
         OP_RTYPE:                         target = S_RTEXE;
         OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: target = S_ITEXE;
         OP_LW, OP_SW:                     target = S_MEMADR;
         OP_BEQ, OP_BNE:                   target = S_BRANCH;
         OP_J:                             target = S_JUMP;
`ifdef MULTICYCLE_CTRL_JAL_EN
         OP_JAL:                           target = S_JAL;
`endif
         default:                          target = S_FETCH;
      endcase
      return target;
   endfunction

   // ALU operation for the immediate-ALU instructions
   function automatic logic [2:0] itypeAluOp(input logic [5:0] op);
      logic [2:0] code;
      case (op)
         OP_ORI:  code = ALU_OR;
         OP_ANDI: code = ALU_AND;
         OP_LUI:  code = ALU_LUI;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode
// Purely combinational control-word table: turns the current FSM state and the
// latched opcode into every datapath control for this cycle.
//
// Ports:
//   state     in   current FSM state
//   opQ       in   opcode latched at the end of DECODE
//   opIn      in   live opcode from the IR, only used to flag illegal ops in DECODE
//   memReady  in   memory handshake, qualifies IRWrite/PCWrite in FETCH
//   ctrl      out  packed control word
//
// Configuration macro: MULTICYCLE_CTRL_JAL_EN enables the JAL state row.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_e     state,
   input  logic [5:0] opQ,
   input  logic [5:0] opIn,
   input  logic       memReady,
   output ctrlWord_t  ctrl
);

   // Moore table. Everything defaults to zero so IDLE and the unused encodings
   // drive a quiet datapath; each state only lists the controls it asserts.
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.iorD     = 1'b0;
            ctrl.memRead  = 1'b1;
            ctrl.aluSrcA  = 1'b0;
            ctrl.aluSrcB  = SRCB_FOUR;
            ctrl.aluOp    = ALU_ADD;
            ctrl.pcSource = PCSRC_ALU;
            ctrl.irWrite  = memReady;
            ctrl.pcWrite  = memReady;
         end
         S_DECODE: begin
            ctrl.aluSrcA   = 1'b0;
            ctrl.aluSrcB   = SRCB_BRANCH;
            ctrl.aluOp     = ALU_ADD;
            ctrl.illegalOp = (opTarget(opIn) == S_FETCH);
         end
         S_RTEXE: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_RT;
            ctrl.aluOp   = ALU_R;
         end
         S_RTWB: begin
            ctrl.regDst   = REGDST_RD;
            ctrl.memtoReg = MEMTOREG_ALUOUT;
            ctrl.regWrite = 1'b1;
         end
         S_ITEXE: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = itypeAluOp(opQ);
         end
         S_ITWB: begin
            ctrl.regDst   = REGDST_RT;
            ctrl.memtoReg = MEMTOREG_ALUOUT;
            ctrl.regWrite = 1'b1;
         end
         S_MEMADR: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALU_ADD;
         end
         S_MEMRD: begin
            ctrl.iorD    = 1'b1;
            ctrl.memRead = 1'b1;
         end
         S_MEMWB: begin
            ctrl.regDst   = REGDST_RT;
            ctrl.memtoReg = MEMTOREG_MDR;
            ctrl.regWrite = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iorD     = 1'b1;
            ctrl.memWrite = 1'b1;
         end
         S_BRANCH: begin
            ctrl.aluSrcA  = 1'b1;
            ctrl.aluSrcB  = SRCB_RT;
            ctrl.pcSource = PCSRC_ALUOUT;
            if (opQ == OP_BNE) begin
               ctrl.aluOp    = ALU_BNE;
               ctrl.branchNe = 1'b1;
            end else begin
               ctrl.aluOp    = ALU_BEQ;
               ctrl.branchEq = 1'b1;
            end
         end
         S_JUMP: begin
            ctrl.pcSource = PCSRC_JUMP;
            ctrl.pcWrite  = 1'b1;
         end
`ifdef MULTICYCLE_CTRL_JAL_EN
         S_JAL: begin
            ctrl.pcSource = PCSRC_JUMP;
            ctrl.pcWrite  = 1'b1;
            ctrl.regDst   = REGDST_RA;
            ctrl.memtoReg = MEMTOREG_PC;
            ctrl.regWrite = 1'b1;
         end
`endif
         default: begin
            ctrl = '0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle control FSM for the MIPS core. Walks each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB, waits on the memory handshake, flags unknown
// opcodes and counts retired instructions.
//
// Parameters:
//   ALUOP_W  width of the ALUOp output (codes are 3 bits, zero-extended)
//   CNT_W    width of the retired-instruction counter
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   OP           opcode from IR[31:26]
//   mem_ready    memory completes the current access this cycle
//   PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
//   RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp
//                datapath controls
//   illegal_op   unknown opcode seen in DECODE
//   instr_count  retired instructions, wraps modulo 2^CNT_W
//
// Configuration macro: MULTICYCLE_CTRL_JAL_EN adds the JAL instruction (opcode 03).
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         OP,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               BranchEQ,
   output logic               BranchNE,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemtoReg,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               illegal_op,
   output logic [CNT_W-1:0]   instr_count
);

   state_e           stateQ;
   state_e           stateNext;
   logic [5:0]       opQ;
   logic [CNT_W-1:0] instrCount;
   logic             retire;
   ctrlWord_t        ctrl;

   // State register. Reset drops straight to IDLE so the datapath sees an
   // all-zero control word while reset is held, whatever state we were in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ <= S_IDLE;
      end else begin
         stateQ <= stateNext;
      end
   end

   // Opcode latch and retirement counter. The opcode is captured while in
   // DECODE so the later states still know which instruction they serve
   // after the IR may have moved on.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         opQ        <= '0;
         instrCount <= '0;
      end else begin
         if (stateQ == S_DECODE) begin
            opQ <= OP;
         end
         if (retire) begin
            instrCount <= instrCount + CNT_W'(1);
         end
      end
   end

   // Next-state logic. retire marks the final cycle of every legal
   // instruction; illegal opcodes go back to FETCH from DECODE without it.
   always_comb begin
      stateNext = stateQ;
      retire    = 1'b0;
      case (stateQ)
         S_IDLE:   stateNext = S_FETCH;
         S_FETCH: begin
            if (mem_ready) begin
               stateNext = S_DECODE;
            end
         end
         S_DECODE: stateNext = opTarget(OP);
         S_RTEXE:  stateNext = S_RTWB;
         S_RTWB: begin
            stateNext = S_FETCH;
            retire    = 1'b1;
         end
         S_ITEXE:  stateNext = S_ITWB;
         S_ITWB: begin
            stateNext = S_FETCH;
            retire    = 1'b1;
         end
         S_MEMADR: stateNext = (opQ == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (mem_ready) begin
               stateNext = S_MEMWB;
            end
         end
         S_MEMWB: begin
            stateNext = S_FETCH;
            retire    = 1'b1;
         end
         S_MEMWR: begin
            if (mem_ready) begin
               stateNext = S_FETCH;
               retire    = 1'b1;
            end
         end
         S_BRANCH: begin
            stateNext = S_FETCH;
            retire    = 1'b1;
         end
         S_JUMP: begin
            stateNext = S_FETCH;
            retire    = 1'b1;
         end
`ifdef MULTICYCLE_CTRL_JAL_EN
         S_JAL: begin
            stateNext = S_FETCH;
            retire    = 1'b1;
         end
`endif
         default:  stateNext = S_FETCH;
      endcase
   end

   mips_ctrl_decode uDecode (
      .state    (stateQ),
      .opQ      (opQ),
      .opIn     (OP),
      .memReady (mem_ready),
      .ctrl     (ctrl)
   );

   // Unpack the control word onto the datapath-facing ports
   assign PCWrite     = ctrl.pcWrite;
   assign BranchEQ    = ctrl.branchEq;
   assign BranchNE    = ctrl.branchNe;
   assign IorD        = ctrl.iorD;
   assign MemRead     = ctrl.memRead;
   assign MemWrite    = ctrl.memWrite;
   assign IRWrite     = ctrl.irWrite;
   assign RegDst      = ctrl.regDst;
   assign MemtoReg    = ctrl.memtoReg;
   assign RegWrite    = ctrl.regWrite;
   assign ALUSrcA     = ctrl.aluSrcA;
   assign ALUSrcB     = ctrl.aluSrcB;
   assign PCSource    = ctrl.pcSource;
   assign ALUOp       = ALUOP_W'(ctrl.aluOp);
   assign illegal_op  = ctrl.illegalOp;
   assign instr_count = instrCount;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed bench for multicycle_control: walks R-type, LW with memory stalls,
// BNE/BEQ, ORI, SW, J, an illegal opcode, opcode 03 (JAL or illegal depending
// on MULTICYCLE_CTRL_JAL_EN) and an asynchronous reset during MEMRD.
module tb_multicycle_control;

   logic        clk;
   logic        reset;
   logic [5:0]  OP;
   logic        mem_ready;
   logic        PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite;
   logic [1:0]  RegDst, MemtoReg;
   logic        RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, PCSource;
   logic [2:0]  ALUOp;
   logic        illegal_op;
   logic [31:0] instr_count;

   int testCount;
   int failCount;

   multicycle_control #(.ALUOP_W(3), .CNT_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .OP          (OP),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .BranchEQ    (BranchEQ),
      .BranchNE    (BranchNE),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .RegDst      (RegDst),
      .MemtoReg    (MemtoReg),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .PCSource    (PCSource),
      .ALUOp       (ALUOp),
      .illegal_op  (illegal_op),
      .instr_count (instr_count)
   );

   // Free-running clock, rising edge at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // All control outputs packed in one word so each cycle is a single comparison
   logic [31:0] obs;
   assign obs = {11'b0, PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                 RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op};

   // Builds the expected word in the same field order as obs
   function automatic logic [31:0] ctlWord(
      input logic pcw, input logic beq, input logic bne, input logic iord,
      input logic mrd, input logic mwr, input logic irw,
      input logic [1:0] regDst, input logic [1:0] m2r, input logic rw,
      input logic srcA, input logic [1:0] srcB, input logic [1:0] pcSrc,
      input logic [2:0] aluOp, input logic ill);
      return {11'b0, pcw, beq, bne, iord, mrd, mwr, irw, regDst, m2r, rw, srcA, srcB, pcSrc, aluOp, ill};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic ready);
      OP        = op;
      mem_ready = ready;
   endtask

   // Advance one clock and settle just past the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] wFetchRdy, wFetchWait, wDecode, wDecodeIll, wRtExe, wRtWb;
   logic [31:0] wOriExe, wItWb, wMemAdr, wMemRd, wMemWb, wMemWr, wBne, wBeq, wJump;
`ifdef MULTICYCLE_CTRL_JAL_EN
   logic [31:0] wJal;
`endif

   initial begin
      testCount = 0;
      failCount = 0;

      //                  pcw beq bne iord mrd mwr irw dst  m2r  rw sA sB    pc    alu     ill
      wFetchRdy  = ctlWord(1, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 0, 0, 2'd1, 2'd0, 3'b100, 0);
      wFetchWait = ctlWord(0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 2'd1, 2'd0, 3'b100, 0);
      wDecode    = ctlWord(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd3, 2'd0, 3'b100, 0);
      wDecodeIll = ctlWord(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd3, 2'd0, 3'b100, 1);
      wRtExe     = ctlWord(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 2'd0, 3'b111, 0);
      wRtWb      = ctlWord(0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 0, 2'd0, 2'd0, 3'b000, 0);
      wOriExe    = ctlWord(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 2'd0, 3'b101, 0);
      wItWb      = ctlWord(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 2'd0, 2'd0, 3'b000, 0);
      wMemAdr    = ctlWord(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 2'd0, 3'b100, 0);
      wMemRd     = ctlWord(0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 2'd0, 3'b000, 0);
      wMemWb     = ctlWord(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 1, 0, 2'd0, 2'd0, 3'b000, 0);
      wMemWr     = ctlWord(0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 2'd0, 3'b000, 0);
      wBne       = ctlWord(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 2'd1, 3'b011, 0);
      wBeq       = ctlWord(0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 2'd1, 3'b010, 0);
      wJump      = ctlWord(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 2'd2, 3'b000, 0);
`ifdef MULTICYCLE_CTRL_JAL_EN
      wJal       = ctlWord(1, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 1, 0, 2'd0, 2'd2, 3'b000, 0);
`endif

      // Reset held: everything quiet
      reset = 1'b0;
      applyStimulus(6'h00, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstWord", obs, 32'd0);
      checkOutput("rstCount", instr_count, 32'd0);

      // Release between edges: IDLE still quiet, then FETCH
      reset = 1'b1;
      #1;
      checkOutput("idleWord", obs, 32'd0);
      tick();
      checkOutput("rFetch", obs, wFetchRdy);

      // R-type, 4 cycles
      tick(); checkOutput("rDecode", obs, wDecode);
      tick(); checkOutput("rExe", obs, wRtExe);
      tick(); checkOutput("rWb", obs, wRtWb);
      checkOutput("rCountBefore", instr_count, 32'd0);
      tick(); checkOutput("rDoneFetch", obs, wFetchRdy);
      checkOutput("rCountAfter", instr_count, 32'd1);

      // FETCH stall, then LW with three wait cycles in MEMRD
      applyStimulus(6'h23, 1'b0);
      #1; checkOutput("fetchWait", obs, wFetchWait);
      tick(); checkOutput("fetchHold", obs, wFetchWait);
      applyStimulus(6'h23, 1'b1);
      #1; checkOutput("fetchGo", obs, wFetchRdy);
      tick(); checkOutput("lwDecode", obs, wDecode);
      tick(); checkOutput("lwMemAdr", obs, wMemAdr);
      applyStimulus(6'h23, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("lwMemRd%0d", i), obs, wMemRd);
         if (i == 3) applyStimulus(6'h23, 1'b1);
         tick();
      end
      checkOutput("lwMemWb", obs, wMemWb);
      tick(); checkOutput("lwDoneFetch", obs, wFetchRdy);
      checkOutput("lwCount", instr_count, 32'd2);

      // BNE, 3 cycles
      applyStimulus(6'h05, 1'b1);
      tick(); checkOutput("bneDecode", obs, wDecode);
      tick(); checkOutput("bneBranch", obs, wBne);
      tick(); checkOutput("bneDoneFetch", obs, wFetchRdy);
      checkOutput("bneCount", instr_count, 32'd3);

      // BEQ, 3 cycles
      applyStimulus(6'h04, 1'b1);
      tick(); checkOutput("beqDecode", obs, wDecode);
      tick(); checkOutput("beqBranch", obs, wBeq);
      tick(); checkOutput("beqCount", instr_count, 32'd4);

      // ORI, 4 cycles
      applyStimulus(6'h0D, 1'b1);
      tick(); checkOutput("oriDecode", obs, wDecode);
      tick(); checkOutput("oriExe", obs, wOriExe);
      tick(); checkOutput("oriWb", obs, wItWb);
      tick(); checkOutput("oriDoneFetch", obs, wFetchRdy);
      checkOutput("oriCount", instr_count, 32'd5);

      // SW with one wait cycle in MEMWR
      applyStimulus(6'h2B, 1'b1);
      tick(); checkOutput("swDecode", obs, wDecode);
      tick(); checkOutput("swMemAdr", obs, wMemAdr);
      applyStimulus(6'h2B, 1'b0);
      tick(); checkOutput("swMemWr0", obs, wMemWr);
      tick(); checkOutput("swMemWr1", obs, wMemWr);
      checkOutput("swHoldCount", instr_count, 32'd5);
      applyStimulus(6'h2B, 1'b1);
      tick(); checkOutput("swDoneFetch", obs, wFetchRdy);
      checkOutput("swCount", instr_count, 32'd6);

      // J, 3 cycles
      applyStimulus(6'h02, 1'b1);
      tick(); checkOutput("jDecode", obs, wDecode);
      tick(); checkOutput("jJump", obs, wJump);
      tick(); checkOutput("jDoneFetch", obs, wFetchRdy);
      checkOutput("jCount", instr_count, 32'd7);

      // Illegal opcode: flagged in DECODE, back to FETCH, not counted
      applyStimulus(6'h3F, 1'b1);
      tick(); checkOutput("illDecode", obs, wDecodeIll);
      tick(); checkOutput("illFetch", obs, wFetchRdy);
      checkOutput("illCount", instr_count, 32'd7);

      // Opcode 03
      applyStimulus(6'h03, 1'b1);
      tick();
`ifdef MULTICYCLE_CTRL_JAL_EN
      checkOutput("jalDecode", obs, wDecode);
      tick(); checkOutput("jalState", obs, wJal);
      tick(); checkOutput("jalDoneFetch", obs, wFetchRdy);
      checkOutput("jalCount", instr_count, 32'd8);
`else
      checkOutput("op03Decode", obs, wDecodeIll);
      tick(); checkOutput("op03Fetch", obs, wFetchRdy);
      checkOutput("op03Count", instr_count, 32'd7);
`endif

      // Asynchronous reset in the middle of a stalled MEMRD
      applyStimulus(6'h23, 1'b1);
      tick(); checkOutput("rstLwDecode", obs, wDecode);
      tick(); checkOutput("rstLwMemAdr", obs, wMemAdr);
      applyStimulus(6'h23, 1'b0);
      tick(); checkOutput("rstLwMemRd", obs, wMemRd);
      #2 reset = 1'b0;
      #1;
      checkOutput("asyncRstWord", obs, 32'd0);
      checkOutput("asyncRstCount", instr_count, 32'd0);
      tick(); checkOutput("asyncRstHold", obs, 32'd0);
      reset = 1'b1;
      #1; checkOutput("relIdle", obs, 32'd0);
      tick(); checkOutput("relFetch", obs, wFetchWait);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
